hard_reset_rx: RTL and testbench



---
 rtl/hard_reset_rx.sv | 134 +++++++++++++
 tb/tb_hard_reset_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hard_reset_rx.sv
// hard_reset_rx: receive-side Hard Reset / Cable Reset handler.
// Optional macro HR_RX_CABLE_RESET_EN enables Cable Reset acceptance.
module hard_reset_rx #(
  parameter int TIMEOUT_CYCLES = 900,
  parameter int CNT_W          = 10
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  iRECEIVE_DETECT,
  input  logic [7:0]  iRECEIVE_BYTE_COUNT,
  input  logic        phy_hr_det,
  input  logic        phy_cr_det,
  input  logic [15:0] alert_clear,
  output logic [15:0] ALERT,
  output logic [7:0]  oRECEIVE_DETECT,
  output logic [7:0]  oRECEIVE_BYTE_COUNT,
  output logic        prl_rx_reset,
  output logic        rx_blocked,
  output logic        hr_type,
  output logic        hr_timeout
);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_RECV    = 5'b00010,
    S_REPORT  = 5'b00100,
    S_WAIT    = 5'b01000,
    S_RESTORE = 5'b10000
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       saved_q;
  logic [7:0]       rd_q;
  logic [7:0]       rbc_q;
  logic             alert_q;
  logic             alert_d;
  logic             prl_q;
  logic             blk_q;
  logic             type_q;
  logic             to_q;
  logic             hr_acc;
  logic             cr_acc;
  logic             accept;
  logic             unused_clr;

  assign hr_acc = phy_hr_det & iRECEIVE_DETECT[5];

`ifdef HR_RX_CABLE_RESET_EN
  assign cr_acc = phy_cr_det & iRECEIVE_DETECT[6];
`else
  logic unused_cr;
  assign cr_acc    = 1'b0;
  assign unused_cr = phy_cr_det;
`endif

  assign accept     = (state_q == S_IDLE) & (hr_acc | cr_acc);
  assign unused_clr = ^{alert_clear[15:4], alert_clear[2:0]};

  // ALERT[3] next value: set on entering HR_REPORT beats a clear strobe
  always_comb begin
    alert_d = alert_q;
    if (state_q == S_RECV)
      alert_d = 1'b1;
    else if (alert_clear[3])
      alert_d = 1'b0;
  end

  // Sequence FSM with registered outputs; values land on state entry
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      saved_q <= '0;
      rd_q    <= '0;
      rbc_q   <= '0;
      alert_q <= 1'b0;
      prl_q   <= 1'b0;
      blk_q   <= 1'b0;
      type_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      alert_q <= alert_d;
      case (state_q)
        S_IDLE: begin
          rd_q  <= iRECEIVE_DETECT;
          rbc_q <= iRECEIVE_BYTE_COUNT;
          if (accept) begin
            saved_q <= iRECEIVE_DETECT;
            rd_q    <= '0;
            rbc_q   <= '0;
            prl_q   <= 1'b1;
            blk_q   <= 1'b1;
            type_q  <= cr_acc & ~hr_acc;
            to_q    <= 1'b0;
            state_q <= S_RECV;
          end
        end
        S_RECV: begin
          prl_q   <= 1'b0;
          state_q <= S_REPORT;
        end
        S_REPORT: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (alert_clear[3]) begin
            state_q <= S_RESTORE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            to_q    <= 1'b1;
            state_q <= S_RESTORE;
          end
        end
        S_RESTORE: begin
          rd_q    <= saved_q;
          blk_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ALERT               = {12'd0, alert_q, 3'd0};
  assign oRECEIVE_DETECT     = rd_q;
  assign oRECEIVE_BYTE_COUNT = rbc_q;
  assign prl_rx_reset        = prl_q;
  assign rx_blocked          = blk_q;
  assign hr_type             = type_q;
  assign hr_timeout          = to_q;

endmodule

// File: tb/tb_hard_reset_rx.sv
// tb_hard_reset_rx: scoreboard bench for hard_reset_rx.
// Expectations are queued per cycle and checked on the falling edge.
module tb_hard_reset_rx;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  iRD = 8'h00;
  logic [7:0]  iRBC = 8'h00;
  logic        hr = 1'b0;
  logic        cr = 1'b0;
  logic [15:0] clr = 16'h0000;
  logic [15:0] ALERT;
  logic [7:0]  oRD;
  logic [7:0]  oRBC;
  logic        prl;
  logic        blk;
  logic        typ;
  logic        tmo;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [35:0] v;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [35:0] act;

  hard_reset_rx #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(10)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .iRECEIVE_DETECT(iRD),
    .iRECEIVE_BYTE_COUNT(iRBC),
    .phy_hr_det(hr),
    .phy_cr_det(cr),
    .alert_clear(clr),
    .ALERT(ALERT),
    .oRECEIVE_DETECT(oRD),
    .oRECEIVE_BYTE_COUNT(oRBC),
    .prl_rx_reset(prl),
    .rx_blocked(blk),
    .hr_type(typ),
    .hr_timeout(tmo)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [35:0] pk(
    logic [15:0] a, logic [7:0] d, logic [7:0] b,
    logic p, logic k, logic t, logic o);
    return {a, d, b, p, k, t, o};
  endfunction

  task automatic push(
    input int c, input string nm,
    input logic [15:0] a, input logic [7:0] d, input logic [7:0] b,
    input logic p, input logic k, input logic t, input logic o);
    exp_t x;
    x.cyc = c;
    x.v   = pk(a, d, b, p, k, t, o);
    x.nm  = nm;
    sb.push_back(x);
  endtask

  task automatic at(input int c);
    @(negedge CLK);
    while (cyc < c) @(negedge CLK);
  endtask

  // Monitor: pop every expectation due this cycle and compare
  always @(negedge CLK) begin
    act = pk(ALERT, oRD, oRBC, prl, blk, typ, tmo);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: cycle %0d passed, now %0d", e.nm, e.cyc, cyc);
      end else if (act !== e.v) begin
        errors++;
        $display("FAIL %s @%0d: got %h required %h", e.nm, cyc, act, e.v);
      end
    end
  end

  initial begin
    int guard;
    iRD  = 8'h21;
    iRBC = 8'h1C;
    // reset state
    at(2);
    push(3, "reset", 16'h0, 8'h00, 8'h00, 0, 0, 0, 0);
    at(3);
    reset = 1'b0;
    push(4, "idle_mirror0", 16'h0, 8'h21, 8'h1C, 0, 0, 0, 0);

    // Hard Reset, cleared by TCPM
    at(10);
    hr = 1'b1;
    push(11, "hr_recv", 16'h0, 8'h00, 8'h00, 1, 1, 0, 0);
    push(12, "hr_report", 16'h8, 8'h00, 8'h00, 0, 1, 0, 0);
    at(11);
    hr = 1'b0;
    at(15);
    hr = 1'b1;
    push(16, "ignore_det", 16'h8, 8'h00, 8'h00, 0, 1, 0, 0);
    at(16);
    hr = 1'b0;
    at(20);
    clr = 16'h0008;
    push(21, "clr_alert", 16'h0, 8'h00, 8'h00, 0, 1, 0, 0);
    push(22, "restore", 16'h0, 8'h21, 8'h00, 0, 0, 0, 0);
    push(23, "idle_mirror1", 16'h0, 8'h21, 8'h1C, 0, 0, 0, 0);
    at(21);
    clr = 16'h0000;

    // Timeout (16 cycles), no clear
    at(30);
    hr = 1'b1;
    push(31, "to_recv", 16'h0, 8'h00, 8'h00, 1, 1, 0, 0);
    push(48, "to_before", 16'h8, 8'h00, 8'h00, 0, 1, 0, 0);
    push(49, "to_rise", 16'h8, 8'h00, 8'h00, 0, 1, 0, 1);
    push(50, "to_restore", 16'h8, 8'h21, 8'h00, 0, 0, 0, 1);
    push(51, "to_idle", 16'h8, 8'h21, 8'h1C, 0, 0, 0, 1);
    at(31);
    hr = 1'b0;
    at(52);
    clr = 16'h0008;
    push(53, "clr_in_idle", 16'h0, 8'h21, 8'h1C, 0, 0, 0, 1);
    at(53);
    clr = 16'h0000;

    // Gating: enable bit low
    at(58);
    iRD = 8'h01;
    at(60);
    hr = 1'b1;
    push(61, "gated0", 16'h0, 8'h01, 8'h1C, 0, 0, 0, 1);
    push(62, "gated1", 16'h0, 8'h01, 8'h1C, 0, 0, 0, 1);
    at(61);
    hr = 1'b0;

    // Cable Reset
    at(68);
    iRD = 8'h40;
    at(70);
    cr = 1'b1;
`ifdef HR_RX_CABLE_RESET_EN
    push(71, "cr_recv", 16'h0, 8'h00, 8'h00, 1, 1, 1, 0);
    push(72, "cr_report", 16'h8, 8'h00, 8'h00, 0, 1, 1, 0);
`else
    push(71, "cr_ign0", 16'h0, 8'h40, 8'h1C, 0, 0, 0, 1);
    push(72, "cr_ign1", 16'h0, 8'h40, 8'h1C, 0, 0, 0, 1);
`endif
    at(71);
    cr = 1'b0;
    at(73);
    clr = 16'h0008;
`ifdef HR_RX_CABLE_RESET_EN
    push(74, "cr_clr", 16'h0, 8'h00, 8'h00, 0, 1, 1, 0);
    push(75, "cr_restore", 16'h0, 8'h40, 8'h00, 0, 0, 1, 0);
`else
    push(74, "cr_ign2", 16'h0, 8'h40, 8'h1C, 0, 0, 0, 1);
    push(75, "cr_ign3", 16'h0, 8'h40, 8'h1C, 0, 0, 0, 1);
`endif
    at(74);
    clr = 16'h0000;

    // Priority, then reset mid-sequence
    at(78);
    iRD = 8'h60;
    at(80);
    hr = 1'b1;
    cr = 1'b1;
    push(81, "prio_hr", 16'h0, 8'h00, 8'h00, 1, 1, 0, 0);
    at(81);
    hr = 1'b0;
    cr = 1'b0;
    at(84);
    reset = 1'b1;
    push(85, "mid_reset", 16'h0, 8'h00, 8'h00, 0, 0, 0, 0);
    at(85);
    reset = 1'b0;
    push(86, "post_reset", 16'h0, 8'h60, 8'h1C, 0, 0, 0, 0);
    at(88);
    hr = 1'b1;
    push(89, "fresh_recv", 16'h0, 8'h00, 8'h00, 1, 1, 0, 0);
    push(90, "fresh_report", 16'h8, 8'h00, 8'h00, 0, 1, 0, 0);
    at(89);
    hr = 1'b0;
    at(91);
    clr = 16'h0008;
    push(92, "fresh_clr", 16'h0, 8'h00, 8'h00, 0, 1, 0, 0);
    push(93, "fresh_restore", 16'h0, 8'h60, 8'h00, 0, 0, 0, 0);
    at(92);
    clr = 16'h0000;

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d pending, required 0", sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
